// File: rtl/systolic_feed_ctrl_pkg.sv
// systolic_feed_ctrl_pkg: shared param.v content (`PE_ROW, `PE_COL, `BIT_DATA, FSM encodings, `DRAIN) plus typed views.
`ifndef SYSTOLIC_FEED_PARAMS
`define SYSTOLIC_FEED_PARAMS
`define PE_ROW 8
`define PE_COL 8
`define BIT_DATA 8
`define DRAIN (`PE_ROW + `PE_COL - 1)
`define ST_IDLE 2'd0
`define ST_FEED 2'd1
`define ST_FLUSH 2'd2
`define ST_DONE 2'd3
`endif
package systolic_feed_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = `ST_IDLE,
    FEED  = `ST_FEED,
    FLUSH = `ST_FLUSH,
    DONE  = `ST_DONE
  } state_e;
  localparam int DRAIN  = `DRAIN;
  localparam int VEC_W  = `PE_ROW * `BIT_DATA;
  localparam int DCNT_W = $clog2(DRAIN + 2);
endpackage

// File: rtl/systolic_feed_addr_gen.sv
// systolic_feed_addr_gen: read-address and remaining-length sequencer with a last-read flag.
module systolic_feed_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  always_comb begin
    addr_d = load_i ? base_i : step_i ? addr_q + 1'b1 : addr_q;
    rem_d  = load_i ? len_i : step_i ? rem_q - 1'b1 : rem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end
  assign addr_o = addr_q;
  assign last_o = rem_q == LEN_W'(1);
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: streams K buffer rows into the skew loader, then drains zeros through the array.
// Optional FEED_PERF_CNT_EN adds o_Cycle_Cnt, the busy-cycle count of the last job.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_Start,
  input  logic [LEN_W-1:0]  i_K_Len,
  input  logic [ADDR_W-1:0] i_Base_Addr,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [VEC_W-1:0]  i_Rd_Data,
  output logic [VEC_W-1:0]  o_Data_I_In,
  output logic              o_Valid,
  output logic              o_Acc_Clr,
  output logic              o_Busy,
  output logic              o_Done
`ifdef FEED_PERF_CNT_EN
  ,
  output logic [31:0]       o_Cycle_Cnt
`endif
);
  state_e            state_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              rd_en_q, busy_q, done_q;
  logic              vld_q, clr_q, valid_q, acc_clr_q;
  logic [VEC_W-1:0]  data_q;
  logic              start_ok, load, last;
  assign start_ok = state_q == IDLE && i_Start;
  assign load     = start_ok && i_K_Len != '0;
  systolic_feed_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk    (CLK),
    .rst    (RST),
    .load_i (load),
    .step_i (rd_en_q),
    .base_i (i_Base_Addr),
    .len_i  (i_K_Len),
    .addr_o (o_Rd_Addr),
    .last_o (last)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_Start) begin
          if (i_K_Len != '0) begin
            state_q <= FEED;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        FEED: if (last) begin
          state_q <= FLUSH;
          rd_en_q <= 1'b0;
          dcnt_q  <= DCNT_W'(DRAIN + 1);
        end
        FLUSH: if (dcnt_q == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          dcnt_q <= dcnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // clr_q marks the first read of a job; jobs never abut, so rd_en rising is unambiguous
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q     <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      data_q    <= '0;
    end else begin
      vld_q     <= rd_en_q;
      clr_q     <= rd_en_q & ~vld_q;
      valid_q   <= vld_q;
      acc_clr_q <= clr_q;
      data_q    <= vld_q ? i_Rd_Data : '0;
    end
  end
  assign o_Rd_En     = rd_en_q;
  assign o_Data_I_In = data_q;
  assign o_Valid     = valid_q;
  assign o_Acc_Clr   = acc_clr_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
`ifdef FEED_PERF_CNT_EN
  logic [31:0] cyc_cnt_q;
  always_ff @(posedge CLK) begin
    cyc_cnt_q <= RST || start_ok ? '0 : busy_q ? cyc_cnt_q + 32'd1 : cyc_cnt_q;
  end
  assign o_Cycle_Cnt = cyc_cnt_q;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: randomized scoreboard bench; expected events are queued per job and popped by a monitor.
module tb_systolic_feed_ctrl;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int VW = `PE_ROW * `BIT_DATA;
  localparam int DR = `PE_ROW + `PE_COL - 1;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [LW-1:0] k_len = '0;
  logic [AW-1:0] base = '0;
  logic          rd_en, valid, acc_clr, busy, done;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] rd_data = '0, data_out;
`ifdef FEED_PERF_CNT_EN
  logic [31:0]   cyc_cnt;
`endif
  systolic_feed_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .CLK         (clk),
    .RST         (rst),
    .i_Start     (start),
    .i_K_Len     (k_len),
    .i_Base_Addr (base),
    .o_Rd_En     (rd_en),
    .o_Rd_Addr   (rd_addr),
    .i_Rd_Data   (rd_data),
    .o_Data_I_In (data_out),
    .o_Valid     (valid),
    .o_Acc_Clr   (acc_clr),
    .o_Busy      (busy),
    .o_Done      (done)
`ifdef FEED_PERF_CNT_EN
    ,
    .o_Cycle_Cnt (cyc_cnt)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [VW-1:0] mem [1024];
  // Buffer model: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : VW'({$urandom, $urandom});
  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; logic [VW-1:0] data; } vd_t;
  rd_t rd_q[$];
  vd_t vd_q[$];
  int  clr_q[$], done_q[$];
  rd_t re;
  vd_t ve;
  int  ce;
  int  busy_lo = 1, busy_hi = 0, rst_cyc = -1, exp_cnt = 0;
  int  checks = 0, failures = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (cyc >= 1) begin
    if (cyc == rst_cyc) chk("reset_outputs", {rd_en, rd_addr, data_out, valid, acc_clr, busy, done}, '0);
    chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_en_spurious", rd_en, 0);
      else begin
        re = rd_q.pop_front();
        chk("rd_cycle", cyc, re.cyc);
        chk("rd_addr", rd_addr, re.addr);
      end
    end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      re = rd_q.pop_front();
      chk("rd_en_missing", rd_en, 1);
    end
    if (valid) begin
      if (vd_q.size() == 0) chk("valid_spurious", valid, 0);
      else begin
        ve = vd_q.pop_front();
        chk("valid_cycle", cyc, ve.cyc);
        chk("data", data_out, ve.data);
      end
    end else begin
      if (vd_q.size() > 0 && vd_q[0].cyc <= cyc) begin
        ve = vd_q.pop_front();
        chk("valid_missing", valid, 1);
      end
      chk("zero_data", data_out, 0);
    end
    if (acc_clr) begin
      if (clr_q.size() == 0) chk("acc_clr_spurious", acc_clr, 0);
      else begin
        ce = clr_q.pop_front();
        chk("acc_clr_cycle", cyc, ce);
      end
    end else if (clr_q.size() > 0 && clr_q[0] <= cyc) begin
      ce = clr_q.pop_front();
      chk("acc_clr_missing", acc_clr, 1);
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_spurious", done, 0);
      else begin
        ce = done_q.pop_front();
        chk("done_cycle", cyc, ce);
      end
`ifdef FEED_PERF_CNT_EN
      chk("cycle_cnt", cyc_cnt, exp_cnt);
`endif
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      ce = done_q.pop_front();
      chk("done_missing", done, 1);
    end
  end
  // Called at a negedge; returns at the next negedge with i_Start low and inputs scrambled
  task automatic start_job(input int k, input logic [AW-1:0] b, output int c);
    c = cyc;
    start = 1'b1;
    k_len = LW'(k);
    base  = b;
    for (int i = 0; i < k; i++) begin
      rd_q.push_back('{c + 1 + i, AW'(b + i)});
      vd_q.push_back('{c + 3 + i, mem[AW'(b + i)]});
    end
    if (k > 0) begin
      clr_q.push_back(c + 3);
      done_q.push_back(c + k + 3 + DR);
      busy_lo = c + 1;
      busy_hi = c + k + 2 + DR;
      exp_cnt = k + 2 + DR;
    end else begin
      done_q.push_back(c + 1);
      exp_cnt = 0;
    end
    @(negedge clk);
    start = 1'b0;
    k_len = LW'($urandom);
    base  = AW'($urandom);
  endtask
  task automatic finish_job(input int k, input int c);
    repeat ((k > 0 ? c + k + 4 + DR : c + 2) - cyc) @(negedge clk);
`ifdef FEED_PERF_CNT_EN
    chk("cycle_cnt_hold", cyc_cnt, exp_cnt);
`endif
  endtask
  task automatic run_job(input int k, input logic [AW-1:0] b);
    int c;
    start_job(k, b, c);
    finish_job(k, c);
  endtask
  initial begin
    int c, c2, r;
    for (int i = 0; i < 1024; i++) mem[i] = VW'({$urandom, $urandom});
    repeat (2) @(negedge clk);
    chk("reset_state", {rd_en, rd_addr, data_out, valid, acc_clr, busy, done}, '0);
`ifdef FEED_PERF_CNT_EN
    chk("reset_cycle_cnt", cyc_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    run_job(4, 10'h010);
    run_job(0, AW'($urandom));
    run_job(4, 10'h3FE);
    run_job(1, AW'($urandom));
    start_job(4, 10'h123, c);
    start = 1'b1;
    k_len = LW'($urandom_range(1, 9));
    @(negedge clk);
    start = 1'b0;
    repeat (c + 22 - cyc) @(negedge clk);
    start = 1'b1;
    k_len = LW'($urandom_range(0, 9));
    base  = AW'($urandom);
    @(negedge clk);
    start_job(4, 10'h200, c2);
    finish_job(4, c2);
    start_job(8, AW'($urandom), c);
    repeat (c + 4 - cyc) @(negedge clk);
    r = cyc;
    rst = 1'b1;
    while (rd_q.size() > 0 && rd_q[$].cyc > r) re = rd_q.pop_back();
    while (vd_q.size() > 0 && vd_q[$].cyc > r) ve = vd_q.pop_back();
    while (clr_q.size() > 0 && clr_q[$] > r) ce = clr_q.pop_back();
    while (done_q.size() > 0 && done_q[$] > r) ce = done_q.pop_back();
    busy_hi = r;
    rst_cyc = r + 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_job(8, AW'($urandom));
    for (int j = 0; j < 8; j++) run_job($urandom_range(0, 20), AW'($urandom));
    repeat (3) @(negedge clk);
    chk("leftover_expected", rd_q.size() + vd_q.size() + clr_q.size() + done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: input-buffer read address width.
REQ-002 Parameter LEN_W, default 16: width of the job length field.
REQ-003 Compile-time constants `PE_ROW, `PE_COL and `BIT_DATA SHALL come from param.v.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 i_Start  input  1  job start pulse, sampled only in IDLE.
REQ-007 i_K_Len  input  LEN_W  number of row-vectors to feed, sampled with i_Start.
REQ-008 i_Base_Addr  input  ADDR_W  first buffer address, sampled with i_Start.
REQ-009 o_Rd_En  output  1  buffer read strobe.
REQ-010 o_Rd_Addr  output  ADDR_W  buffer read address.
REQ-011 i_Rd_Data  input  `PE_ROW*`BIT_DATA  buffer data, valid exactly 1 cycle after o_Rd_En.
REQ-012 o_Data_I_In  output  `PE_ROW*`BIT_DATA  registered vector to the skew loader.
REQ-013 o_Valid  output  1  o_Data_I_In carries real data.
REQ-014 o_Acc_Clr  output  1  one-cycle pulse telling the PEs to clear their accumulators.
REQ-015 o_Busy  output  1  job in progress.
REQ-016 o_Done  output  1  one-cycle job-complete pulse.

Function
REQ-017 FSM states SHALL be IDLE, FEED, FLUSH and DONE.
REQ-018 IDLE->FEED on i_Start with i_K_Len>0; IDLE->DONE on i_Start with i_K_Len==0; FEED->FLUSH after K read cycles; FLUSH->DONE after the last drain cycle; DONE->IDLE unconditionally.
REQ-019 With i_Start sampled in cycle 0: o_Rd_En SHALL be 1 in cycles 1..K, and o_Rd_Addr in cycle n SHALL equal i_Base_Addr+n-1.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-021 o_Data_I_In SHALL register i_Rd_Data, giving data with o_Valid=1 in cycles 3..K+2; all data is 2 cycles after the matching o_Rd_En.
REQ-022 Whenever o_Valid=0, o_Data_I_In SHALL be all zeros, so the skew stages drain zeros.
REQ-023 o_Acc_Clr SHALL be 1 only in cycle 3, the first valid cycle.
REQ-024 The drain length SHALL be DRAIN=`PE_ROW+`PE_COL-1 cycles of zero data following the last valid cycle (cycles K+3..K+2+DRAIN).
REQ-025 o_Done SHALL pulse in cycle K+3+DRAIN (DONE state).
REQ-026 o_Busy SHALL be 1 in cycles 1..K+2+DRAIN and 0 in IDLE and DONE.
REQ-027 When i_K_Len==0: no o_Rd_En, no o_Valid, no o_Acc_Clr, o_Busy never set, and o_Done in cycle 1.
REQ-028 i_Start outside IDLE SHALL be ignored, including in the DONE cycle; i_K_Len and i_Base_Addr changes after sampling SHALL have no effect.
REQ-029 The length counter SHALL hold K up to 2^LEN_W-1 without overflow.

Reset
REQ-030 When RST=1, the FSM SHALL enter IDLE, counters SHALL clear, and in-flight read data SHALL be discarded.
REQ-031 Reset values SHALL be o_Rd_En=0, o_Rd_Addr=0, o_Data_I_In=0, o_Valid=0, o_Acc_Clr=0, o_Busy=0, o_Done=0.
REQ-032 Reset asserted mid-job SHALL take effect next edge with no o_Done pulse.

Configuration
REQ-033 With FEED_PERF_CNT_EN defined: output o_Cycle_Cnt [31:0] SHALL be present, cleared to 0 on an accepted i_Start and on RST, incremented each cycle o_Busy=1, and held after o_Done.
REQ-034 Without FEED_PERF_CNT_EN the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-035 FSM state encodings and the DRAIN constant SHALL live in shared param.v alongside `PE_ROW, `PE_COL and `BIT_DATA.
REQ-036 Address/length sequencing SHALL be one sub-module, systolic_feed_addr_gen (load, step, last flag); the FSM and data path stay in the top level.

Verification
REQ-037 PE 8x8, K=4, base=0x010: o_Rd_En in cycles 1-4 with addresses 0x010-0x013; o_Valid in cycles 3-6; o_Acc_Clr in cycle 3; zero data in cycles 7-21; o_Done in cycle 22.
REQ-038 K=0: o_Done in cycle 1; o_Rd_En, o_Valid and o_Busy never asserted.
REQ-039 base=0x3FE, K=4, ADDR_W=10: addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-040 i_Start pulsed in cycles 2 and 22 of a K=4 job: both ignored, exactly one o_Done; a new start in cycle 23 (IDLE) is accepted.
REQ-041 RST in cycle 4 of a K=8 job: all outputs reach reset values in cycle 5, no o_Valid or o_Done follows, and a fresh job then runs correctly.
REQ-042 FEED_PERF_CNT_EN defined, K=4 on 8x8: o_Cycle_Cnt=21 after o_Done and held until the next start.
